mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store sequencer for the RISC-V memory stage, directly upstream of the byte-addressable data memory. It accepts one load or store per valid/ready handshake from execute and decodes funct3 into the data memory's read/write control codes. It rejects misaligned, out-of-range and illegal accesses without touching memory, and returns a registered response (load data, destination register, fault code) to writeback.

## Interface
- No parameters; data memory is fixed at 256 bytes (8-bit byte address).
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store: 000 sb, 001 sh, 010 sw)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- req_rd  in  5  load destination register
- resp_valid  out  1  response present
- resp_ready  in  1  writeback accepts response
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_rd  out  5  destination; forced 0 for stores and faults
- resp_fault  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 address ≥ 256
- mem_read_ctrl  out  3  data memory ReadControl; 3'b111 when idle
- mem_write_ctrl  out  3  data memory WriteControl; 3'b111 when idle (000 means sb, so never idle at 000)
- mem_addr  out  8  data memory byte address
- mem_wdata  out  32  data memory write data
- mem_rdata  in  32  data memory ReadData (combinational from mem_addr/mem_read_ctrl)

## Operation
- States: IDLE, ISSUE, RESP.
- req_ready = (state==IDLE) | (state==RESP & resp_ready). This is combinational through resp_ready.
- Accept (req_valid & req_ready): latch we, funct3, addr, wdata, rd. Compute fault in priority order: illegal funct3 (10), then addr[31:8]≠0 (11), then misaligned (01: halfword with addr[0]=1; word with addr[1:0]≠0).
- Accept with fault==00 → ISSUE. Accept with fault≠00 → RESP directly, with resp_rdata=0, resp_rd=0, and no memory control activity.
- ISSUE (exactly one cycle): mem_addr=addr[7:0], mem_wdata=wdata.
  - Load: mem_read_ctrl=funct3, mem_write_ctrl=111.
  - Store: mem_write_ctrl=funct3, mem_read_ctrl=111.
- Closing edge of ISSUE: the store commits in memory; for a load, mem_rdata is captured into resp_rdata and resp_rd=rd; for a store, resp_rdata=0 and resp_rd=0. Next state RESP.
- RESP: resp_valid=1; all resp_* held stable until resp_ready=1.
  - resp_ready & req_valid: pop and accept in the same edge.
  - resp_ready & !req_valid: → IDLE.
- mem_*_ctrl, mem_addr and mem_wdata are registered outputs. Outside ISSUE, both ctrls are 111, mem_addr is 0 and mem_wdata is 0.
- Sign/zero extension is performed by the memory; this unit passes mem_rdata through unchanged.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_rd=0, resp_fault=00, mem_read_ctrl=111, mem_write_ctrl=111, mem_addr=0, mem_wdata=0.
- Latency, accept edge E0 to resp_valid:
  - Legal access: resp_valid high after E0+1 (ISSUE occupies cycle E0→E0+1).
  - Faulted access: resp_valid high after E0.
- Throughput: one legal access per 2 cycles with resp_ready held high; one faulted access per cycle.
- rst asserted during ISSUE: controls return to 111 immediately (asynchronously), so no store commits at the next edge; the in-flight response is discarded.
- rst asserted during RESP: resp_valid drops immediately; the response is lost.
- req_valid while busy (req_ready=0): the request is ignored, and upstream must hold it.

## Test plan
- sb addr 0x05 wdata 0x1234_5680, then lb 0x05 → resp_rdata 0xFFFF_FF80, resp_rd=req_rd, fault 00; lbu 0x05 → 0x0000_0080; lw 0x04 → 0x0000_8000.
- sw 0x08 wdata 0xDEAD_BEEF, then lh 0x0A → 0xFFFF_DEAD and lhu 0x08 → 0x0000_BEEF. Check resp_valid exactly 2 edges after each accept.
- lw 0x06 and sh 0x03 → fault 01 one edge after accept, resp_rdata 0, and mem_write_ctrl/mem_read_ctrl stay 111 every cycle; a following lw 0x04 returns unchanged data.
- sw 0x100 → fault 11; load funct3 011 → fault 10; store funct3 100 → fault 10. No memory activity in any case.
- lw with resp_ready low for 3 cycles → resp_* stable, req_ready=0, new req_valid ignored. On the cycle resp_ready rises with req_valid high, the pop and the new accept happen on the same edge.
- sw 0x10 wdata 0xFFFF_FFFF, then assert rst mid-ISSUE → mem_write_ctrl goes to 111 before the edge; after reset, lw 0x10 returns 0 and all outputs match the reset values.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer for the memory stage: validates each request, issues one registered
// control cycle to the byte-addressable data memory, and holds a registered response for writeback.
//
// state | meaning
// IDLE  | no request in flight, ready to accept
// ISSUE | memory controls driven for exactly one cycle
// RESP  | response held until writeback takes it
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic [1:0]  resp_fault,
    output logic [2:0]  mem_read_ctrl,
    output logic [2:0]  mem_write_ctrl,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [2:0] CTRL_IDLE = 3'b111;

    localparam logic [1:0] FAULT_OK      = 2'b00;
    localparam logic [1:0] FAULT_MISALGN = 2'b01;
    localparam logic [1:0] FAULT_FUNCT3  = 2'b10;
    localparam logic [1:0] FAULT_RANGE   = 2'b11;

    logic [1:0] state;
    logic       op_we;
    logic [4:0] op_rd;

    logic       accept;
    logic       funct3_legal;
    logic       misaligned;
    logic [1:0] req_fault;

    assign req_ready = (state == IDLE) | ((state == RESP) & resp_ready);
    assign accept    = req_valid & req_ready;

    always_comb begin
        funct3_legal = 1'b0;
        if (req_we) begin
            funct3_legal = (req_funct3 == 3'b000) | (req_funct3 == 3'b001) | (req_funct3 == 3'b010);
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_legal = 1'b1;
                default:                                funct3_legal = 1'b0;
            endcase
        end
    end

    // funct3[1:0] encodes the access size for every legal code: 01 halfword, 10 word
    assign misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                        ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));

    always_comb begin
        if (!funct3_legal)            req_fault = FAULT_FUNCT3;
        else if (|req_addr[31:8])     req_fault = FAULT_RANGE;
        else if (misaligned)          req_fault = FAULT_MISALGN;
        else                          req_fault = FAULT_OK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            op_we          <= 1'b0;
            op_rd          <= 5'd0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            resp_rd        <= 5'd0;
            resp_fault     <= FAULT_OK;
            mem_read_ctrl  <= CTRL_IDLE;
            mem_write_ctrl <= CTRL_IDLE;
            mem_addr       <= 8'd0;
            mem_wdata      <= 32'd0;
        end else begin
            // memory port is quiet unless a legal accept below overrides it
            mem_read_ctrl  <= CTRL_IDLE;
            mem_write_ctrl <= CTRL_IDLE;
            mem_addr       <= 8'd0;
            mem_wdata      <= 32'd0;

            case (state)
                IDLE: ;
                ISSUE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_fault <= FAULT_OK;
                    resp_rdata <= op_we ? 32'd0 : mem_rdata;
                    resp_rd    <= op_we ? 5'd0 : op_rd;
                end
                RESP: begin
                    if (resp_ready & ~req_valid) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                op_we <= req_we;
                op_rd <= req_rd;
                if (req_fault == FAULT_OK) begin
                    state      <= ISSUE;
                    resp_valid <= 1'b0;
                    mem_addr   <= req_addr[7:0];
                    mem_wdata  <= req_wdata;
                    if (req_we) mem_write_ctrl <= req_funct3;
                    else        mem_read_ctrl  <= req_funct3;
                end else begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_fault <= req_fault;
                    resp_rdata <= 32'd0;
                    resp_rd    <= 5'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, back-pressure and reset sequences,
// then random traffic against a byte-array reference of the data memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_fault;
    logic [2:0]  mem_read_ctrl;
    logic [2:0]  mem_write_ctrl;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_fault(resp_fault),
        .mem_read_ctrl(mem_read_ctrl), .mem_write_ctrl(mem_write_ctrl),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // data memory attached to the DUT: combinational read with extension, write at the edge
    logic [7:0] mem_bytes [256] = '{default: 8'h00};
    logic [7:0] ref_bytes [256] = '{default: 8'h00};
    int act_cnt = 0;

    always_comb begin
        mem_rdata = 32'h0;
        case (mem_read_ctrl)
            3'b000: mem_rdata = {{24{mem_bytes[mem_addr][7]}}, mem_bytes[mem_addr]};
            3'b001: mem_rdata = {{16{mem_bytes[mem_addr+8'd1][7]}}, mem_bytes[mem_addr+8'd1], mem_bytes[mem_addr]};
            3'b010: mem_rdata = {mem_bytes[mem_addr+8'd3], mem_bytes[mem_addr+8'd2],
                                 mem_bytes[mem_addr+8'd1], mem_bytes[mem_addr]};
            3'b100: mem_rdata = {24'h0, mem_bytes[mem_addr]};
            3'b101: mem_rdata = {16'h0, mem_bytes[mem_addr+8'd1], mem_bytes[mem_addr]};
            default: mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        case (mem_write_ctrl)
            3'b000: mem_bytes[mem_addr] <= mem_wdata[7:0];
            3'b001: begin
                mem_bytes[mem_addr]      <= mem_wdata[7:0];
                mem_bytes[mem_addr+8'd1] <= mem_wdata[15:8];
            end
            3'b010: begin
                mem_bytes[mem_addr]      <= mem_wdata[7:0];
                mem_bytes[mem_addr+8'd1] <= mem_wdata[15:8];
                mem_bytes[mem_addr+8'd2] <= mem_wdata[23:16];
                mem_bytes[mem_addr+8'd3] <= mem_wdata[31:24];
            end
            default: ;
        endcase
        if (mem_read_ctrl != 3'b111 || mem_write_ctrl != 3'b111) act_cnt <= act_cnt + 1;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference rules written from the ISA view: size, legality, range, alignment
    function automatic int access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [1:0] model_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 2'b10;
        if (addr > 32'd255) return 2'b11;
        if ((addr % access_size(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [7:0] a);
        logic [31:0] w;
        w = {ref_bytes[a+8'd3], ref_bytes[a+8'd2], ref_bytes[a+8'd1], ref_bytes[a]};
        case (f3)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd1:    return {{16{w[15]}}, w[15:0]};
            3'd4:    return {24'h0, w[7:0]};
            3'd5:    return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"},  32'(req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "_resp_rd"},    32'(resp_rd), 32'd0);
        check({tag, "_resp_fault"}, 32'(resp_fault), 32'd0);
        check({tag, "_ctrls"},      32'({mem_read_ctrl, mem_write_ctrl}), 32'h3f);
        check({tag, "_mem_addr"},   32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"},  mem_wdata, 32'd0);
    endtask

    // one complete transaction: accept, latency, issue cycle, response, stall, pop
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input logic [31:0] exp_rdata, input logic [1:0] exp_fault,
                           input int stall, input string tag);
        int acts0;
        int waitc;
        logic [4:0] exp_rd;
        exp_rd = (!we && exp_fault == 2'b00) ? rd : 5'd0;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        req_valid = 1'b1; resp_ready = 1'b0;
        #1;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(posedge clk); #1; waitc++;
        end
        if (!req_ready) begin
            check({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        acts0 = act_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (exp_fault == 2'b00) begin
            check({tag, "_issue_valid"}, 32'(resp_valid), 32'd0);
            check({tag, "_issue_ready"}, 32'(req_ready), 32'd0);
            check({tag, "_issue_rctrl"}, 32'(mem_read_ctrl), we ? 32'd7 : 32'(f3));
            check({tag, "_issue_wctrl"}, 32'(mem_write_ctrl), we ? 32'(f3) : 32'd7);
            check({tag, "_issue_addr"},  32'(mem_addr), 32'(addr[7:0]));
            check({tag, "_issue_wdata"}, mem_wdata, wdata);
            @(posedge clk); #1;
        end
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_rdata"},      resp_rdata, exp_rdata);
        check({tag, "_rd"},         32'(resp_rd), 32'(exp_rd));
        check({tag, "_fault"},      32'(resp_fault), 32'(exp_fault));
        check({tag, "_resp_ctrls"}, 32'({mem_read_ctrl, mem_write_ctrl}), 32'h3f);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, "_stall_valid"}, 32'(resp_valid), 32'd1);
            check({tag, "_stall_rdata"}, resp_rdata, exp_rdata);
            check({tag, "_stall_fault"}, 32'(resp_fault), 32'(exp_fault));
            check({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        #1;
        check({tag, "_pop_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check({tag, "_popped"}, 32'(resp_valid), 32'd0);
        resp_ready = 1'b0;
        check({tag, "_mem_cycles"}, 32'(act_cnt - acts0), (exp_fault == 2'b00) ? 32'd1 : 32'd0);
        if (we && exp_fault == 2'b00)
            for (int i = 0; i < access_size(f3); i++) ref_bytes[addr[7:0] + 8'(i)] = wdata[8*i +: 8];
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_fault;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;
        logic [4:0]  r_rd;
        logic [1:0]  r_fault;
        logic [31:0] r_rdata;

        vecs[0]  = '{1'b1, 3'd0, 32'h05,  32'h1234_5680, 5'd7,  32'h0,         2'b00};
        vecs[1]  = '{1'b0, 3'd0, 32'h05,  32'h0,         5'd3,  32'hFFFF_FF80, 2'b00};
        vecs[2]  = '{1'b0, 3'd4, 32'h05,  32'h0,         5'd4,  32'h0000_0080, 2'b00};
        vecs[3]  = '{1'b0, 3'd2, 32'h04,  32'h0,         5'd5,  32'h0000_8000, 2'b00};
        vecs[4]  = '{1'b1, 3'd2, 32'h08,  32'hDEAD_BEEF, 5'd6,  32'h0,         2'b00};
        vecs[5]  = '{1'b0, 3'd1, 32'h0A,  32'h0,         5'd8,  32'hFFFF_DEAD, 2'b00};
        vecs[6]  = '{1'b0, 3'd5, 32'h08,  32'h0,         5'd31, 32'h0000_BEEF, 2'b00};
        vecs[7]  = '{1'b0, 3'd2, 32'h06,  32'h0,         5'd9,  32'h0,         2'b01};
        vecs[8]  = '{1'b1, 3'd1, 32'h03,  32'hAAAA_5555, 5'd2,  32'h0,         2'b01};
        vecs[9]  = '{1'b0, 3'd2, 32'h04,  32'h0,         5'd10, 32'h0000_8000, 2'b00};
        vecs[10] = '{1'b1, 3'd2, 32'h100, 32'h1111_1111, 5'd1,  32'h0,         2'b11};
        vecs[11] = '{1'b0, 3'd3, 32'h04,  32'h0,         5'd11, 32'h0,         2'b10};
        vecs[12] = '{1'b1, 3'd4, 32'h04,  32'h2222_2222, 5'd12, 32'h0,         2'b10};
        vecs[13] = '{1'b0, 3'd6, 32'h101, 32'h0,         5'd13, 32'h0,         2'b10};
        vecs[14] = '{1'b1, 3'd1, 32'h201, 32'h3333_3333, 5'd14, 32'h0,         2'b11};

        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        #2;
        check_reset_values("por");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_reset_values("post_por");

        for (int i = 0; i < 15; i++)
            run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rd,
                    vecs[i].exp_rdata, vecs[i].exp_fault, (i % 4 == 3) ? 2 : 0,
                    $sformatf("vec%0d", i));

        // back-pressure: response held 3 cycles with a new request waiting, then pop+accept together
        req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h08; req_wdata = 32'd0; req_rd = 5'd9;
        req_valid = 1'b1; resp_ready = 1'b0;
        #1;
        check("bp_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_resp_valid", 32'(resp_valid), 32'd1);
        check("bp_rdata", resp_rdata, 32'hDEAD_BEEF);
        check("bp_rd", 32'(resp_rd), 32'd9);
        req_funct3 = 3'd4; req_addr = 32'h08; req_rd = 5'd12; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            check("bp_hold_valid", 32'(resp_valid), 32'd1);
            check("bp_hold_rdata", resp_rdata, 32'hDEAD_BEEF);
            check("bp_hold_rd", 32'(resp_rd), 32'd9);
            check("bp_hold_rctrl", 32'(mem_read_ctrl), 32'd7);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        #1;
        check("bp_pop_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_issue_valid", 32'(resp_valid), 32'd0);
        check("bp_issue_rctrl", 32'(mem_read_ctrl), 32'd4);
        check("bp_issue_addr", 32'(mem_addr), 32'h08);
        @(posedge clk); #1;
        check("bp2_valid", 32'(resp_valid), 32'd1);
        check("bp2_rdata", resp_rdata, 32'h0000_00EF);
        check("bp2_rd", 32'(resp_rd), 32'd12);
        @(posedge clk); #1;
        check("bp2_popped", 32'(resp_valid), 32'd0);
        resp_ready = 1'b0;

        // reset during ISSUE of a store: write control must drop before the commit edge
        req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF; req_rd = 5'd0;
        req_valid = 1'b1;
        #1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_issue_wctrl", 32'(mem_write_ctrl), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_wctrl", 32'(mem_write_ctrl), 32'd7);
        check("rst_async_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_reset_values("after_rst");
        run_txn(1'b0, 3'd2, 32'h10, 32'h0, 5'd15, 32'h0, 2'b00, 0, "rst_lw");

        for (int n = 0; n < 80; n++) begin
            r_we = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) r_addr = $urandom;
            else r_addr = {24'h0, 8'($urandom_range(0, 255))};
            if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
            r_wdata = $urandom;
            r_rd = 5'($urandom_range(0, 31));
            r_fault = model_fault(r_we, r_f3, r_addr);
            r_rdata = (r_fault == 2'b00 && !r_we) ? model_load(r_f3, r_addr[7:0]) : 32'h0;
            run_txn(r_we, r_f3, r_addr, r_wdata, r_rd, r_rdata, r_fault,
                    $urandom_range(0, 2), $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
